// File: rtl/uart_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched_pkg
//  Description : Shared definitions for the UART transmit scheduler:
//                scheduler FSM state encoding and the ASCII line-ending
//                constants used by the optional CR-before-LF insertion.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_sched_pkg;

    // Scheduler FSM states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte-wide synchronous FIFO. A push while full is accepted
//                only when a pop happens on the same edge.
//  Ports       : clk, reset (async, active-high)
//                i_push / i_wr_data  - write request and byte
//                i_pop               - read request (head advances)
//                o_rd_data           - head byte (combinational)
//                o_full / o_empty    - status
//                o_level             - occupancy, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_pop,
    output logic [7:0]               o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   c_full = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == c_full);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a byte if the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers are AW bits wide over a power-of-two depth, so they wrap
    // modulo DEPTH on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Transmit scheduler between the stage controller and the
//                bit-level UART serializer. Buffers loaded bytes in a FIFO
//                and hands them to the serializer one at a time over a
//                start/busy handshake, abandoning the handshake if busy
//                never rises within BUSY_TIMEOUT cycles.
//  Ports       : clk, reset      - clock, async active-high reset
//                UART_load       - one-cycle push request
//                load_data       - byte pushed with UART_load
//                UART_TE         - next UART_load will be accepted
//                tx_start        - one-cycle start pulse to serializer
//                tx_data         - byte for serializer (held until next start)
//                tx_busy         - serializer busy flag
//                fifo_level      - FIFO occupancy
//                overflow        - sticky, a load was dropped
//  Config      : define UART_TX_CRLF_EN to send CR ahead of every LF.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     UART_load,
    input  logic [7:0]               load_data,
    output logic                     UART_TE,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int              LW              = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]   c_full_level    = LW'(DEPTH);
    localparam logic [7:0]      c_busy_timeout  = 8'(BUSY_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_tout_cnt;
    logic [7:0]  w_tout_inc;
    logic        w_tout_hit;
    logic        w_launch;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic [7:0]  w_start_data;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_overflow;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (UART_load),
        .i_wr_data (load_data),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    assign UART_TE  = (fifo_level != c_full_level);
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign overflow = r_overflow;

    // The START state is entered only from IDLE; the start pulse and data
    // are registered on that same edge.
    assign w_launch = (r_state == IDLE) && (w_state_nxt == START);

`ifdef UART_TX_CRLF_EN
    logic r_cr_pending;
    logic w_insert_cr;

    // An LF at the head is first announced by a CR that leaves it in place;
    // the following START then sends and pops the LF itself.
    assign w_insert_cr  = (w_head == ASCII_LF) && !r_cr_pending;
    assign w_start_data = w_insert_cr ? ASCII_CR : w_head;
    assign w_pop        = (r_state == START) && !r_cr_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cr_pending <= 1'b0;
        end else if (w_launch) begin
            r_cr_pending <= w_insert_cr;
        end
    end
`else
    assign w_start_data = w_head;
    assign w_pop        = (r_state == START);
`endif

    // Counter value is the number of WAIT_BUSY cycles already completed;
    // the handshake is abandoned at the end of the BUSY_TIMEOUT-th cycle.
    assign w_tout_inc = r_tout_cnt + 8'd1;
    assign w_tout_hit = (w_tout_inc == c_busy_timeout);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_tout_hit) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tout_cnt <= 8'd0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_start <= w_launch;
            if (w_launch) begin
                r_tx_data <= w_start_data;
            end
            if (r_state == START) begin
                r_tout_cnt <= 8'd0;
            end else if (r_state == WAIT_BUSY) begin
                r_tout_cnt <= w_tout_inc;
            end
            // A load into a full FIFO is dropped unless the head pops now.
            if (UART_load && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Directed self-checking bench for uart_tx_sched (DEPTH=4,
//                BUSY_TIMEOUT=15). A simple serializer model can raise
//                tx_busy one cycle after each start pulse for 10 cycles, or
//                the bench can drive tx_busy directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    logic       clk;
    logic       reset;
    logic       UART_load;
    logic [7:0] load_data;
    logic       UART_TE;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [2:0] fifo_level;
    logic       overflow;

    logic       ser_auto;
    logic       man_busy;
    logic       auto_busy;
    wire        tx_busy = ser_auto ? auto_busy : man_busy;

    int         n_checks;
    int         n_errors;
    int         cyc;
    int         lc;
    logic [7:0] sent_q [$];
    int         start_q [$];

    uart_tx_sched #(
        .DEPTH        (4),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .UART_load  (UART_load),
        .load_data  (load_data),
        .UART_TE    (UART_TE),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every start pulse with its data and the cycle it appeared in.
    always @(negedge clk) begin
        if (tx_start) begin
            sent_q.push_back(tx_data);
            start_q.push_back(cyc);
        end
    end

    // Serializer model: busy rises the cycle after tx_start, held 10 cycles.
    initial auto_busy = 1'b0;
    always begin
        @(negedge clk);
        if (ser_auto && tx_start) begin
            @(posedge clk);
            #1 auto_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1 auto_busy = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        UART_load = 1'b1;
        load_data = b;
        tick();
        UART_load = 1'b0;
        load_data = 8'h00;
    endtask

    task automatic clear_log();
        sent_q.delete();
        start_q.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        reset     = 1'b1;
        UART_load = 1'b0;
        load_data = 8'h00;
        man_busy  = 1'b0;
        ser_auto  = 1'b0;

        // ---------------- reset values ----------------
        #3;
        check("rst_level", fifo_level, 0);
        check("rst_te", UART_TE, 1);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_ovf", overflow, 0);
        tick();
        reset = 1'b0;
        tick();

        // ---------------- single byte ----------------
        ser_auto = 1'b1;
        clear_log();
        load(8'h41);
        lc = cyc;
        check("single_level1", fifo_level, 1);
        tick();
        check("single_start", tx_start, 1);
        check("single_data", tx_data, 8'h41);
        tick();
        check("single_level0", fifo_level, 0);
        check("single_start_drop", tx_start, 0);
        repeat (15) tick();
        check("single_count", sent_q.size(), 1);
        check("single_byte", sent_q[0], 8'h41);
        check("single_latency", start_q[0] - lc, 1);

        // ---------------- push+pop while full ----------------
        ser_auto = 1'b0;
        man_busy = 1'b1;
        load(8'h11);
        load(8'h22);
        load(8'h33);
        load(8'h44);
        check("pp_full_level", fifo_level, 4);
        check("pp_full_te", UART_TE, 0);
        clear_log();
        man_busy = 1'b0;
        tick();
        check("pp_start", tx_start, 1);
        check("pp_start_data", tx_data, 8'h11);
        load(8'hAA);
        check("pp_level", fifo_level, 4);
        check("pp_ovf", overflow, 0);
        ser_auto = 1'b1;
        repeat (100) tick();
        check("pp_count", sent_q.size(), 5);
        check("pp_b0", sent_q[0], 8'h11);
        check("pp_b1", sent_q[1], 8'h22);
        check("pp_b2", sent_q[2], 8'h33);
        check("pp_b3", sent_q[3], 8'h44);
        check("pp_b4", sent_q[4], 8'hAA);
        check("pp_drained", fifo_level, 0);

        // ---------------- fill / overflow ----------------
        ser_auto = 1'b0;
        man_busy = 1'b1;
        load(8'h01);
        load(8'h02);
        load(8'h03);
        check("fill_te3", UART_TE, 1);
        load(8'h04);
        check("fill_te4", UART_TE, 0);
        check("fill_level4", fifo_level, 4);
        check("fill_ovf0", overflow, 0);
        load(8'h05);
        check("fill_ovf1", overflow, 1);
        check("fill_level_hold", fifo_level, 4);
        clear_log();
        ser_auto = 1'b1;
        repeat (70) tick();
        check("fill_count", sent_q.size(), 4);
        check("fill_b0", sent_q[0], 8'h01);
        check("fill_b1", sent_q[1], 8'h02);
        check("fill_b2", sent_q[2], 8'h03);
        check("fill_b3", sent_q[3], 8'h04);
        check("fill_drained", fifo_level, 0);
        check("fill_ovf_sticky", overflow, 1);

        // ---------------- busy timeout ----------------
        ser_auto = 1'b0;
        man_busy = 1'b0;
        clear_log();
        load(8'hC1);
        lc = cyc;
        load(8'hC2);
        repeat (40) tick();
        check("to_count", sent_q.size(), 2);
        check("to_b0", sent_q[0], 8'hC1);
        check("to_b1", sent_q[1], 8'hC2);
        check("to_first", start_q[0] - lc, 1);
        // 1 START + 15 WAIT_BUSY + 1 IDLE cycle between pulses.
        check("to_gap", start_q[1] - start_q[0], 17);

        // ---------------- LF handling ----------------
        ser_auto = 1'b1;
        clear_log();
        load(8'h0A);
        check("lf_level_a", fifo_level, 1);
        tick();
`ifdef UART_TX_CRLF_EN
        check("lf_first_data", tx_data, 8'h0D);
        tick();
        check("lf_level_b", fifo_level, 1);
`else
        check("lf_first_data", tx_data, 8'h0A);
        tick();
        check("lf_level_b", fifo_level, 0);
`endif
        repeat (30) tick();
        check("lf_level_c", fifo_level, 0);
`ifdef UART_TX_CRLF_EN
        check("lf_count", sent_q.size(), 2);
        check("lf_b0", sent_q[0], 8'h0D);
        check("lf_b1", sent_q[1], 8'h0A);
`else
        check("lf_count", sent_q.size(), 1);
        check("lf_b0", sent_q[0], 8'h0A);
`endif

        // ---------------- asynchronous reset mid-transfer ----------------
        ser_auto = 1'b0;
        man_busy = 1'b0;
        load(8'h5A);
        tick();
        check("ar_pre_start", tx_start, 1);
        check("ar_pre_data", tx_data, 8'h5A);
        check("ar_pre_level", fifo_level, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_start", tx_start, 0);
        check("ar_data", tx_data, 8'h00);
        check("ar_level", fifo_level, 0);
        check("ar_te", UART_TE, 1);
        check("ar_ovf", overflow, 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("ar_idle_start", tx_start, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler between the CPU stage controller and the bit-level UART serializer. Accepts byte-load pulses issued during the execute stage, buffers them in a small FIFO, and feeds the serializer one byte at a time over a start/busy handshake. Reports `UART_TE` back to the stage controller so that the SEND stage stalls only while the buffer is full.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `BUSY_TIMEOUT`, 15: cycles to wait for `tx_busy` to rise after `tx_start` before abandoning the handshake; range 1..255.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `UART_load` in 1: one-cycle push request from the stage controller.
- `load_data` in 8: byte pushed when `UART_load`=1.
- `UART_TE` out 1: 1 when the next `UART_load` will be accepted.
- `tx_start` out 1: one-cycle start pulse to the serializer.
- `tx_data` out 8: byte for the serializer; stable from the `tx_start` cycle until the next `tx_start`.
- `tx_busy` in 1: serializer busy flag.
- `fifo_level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky flag; set when a load is dropped.

## Operation
- Reset values: `fifo_level`=0, `UART_TE`=1, `tx_start`=0, `tx_data`=8'h00, `overflow`=0, FSM in IDLE, `cr_pending`=0, timeout counter=0.
- Push: on an edge with `UART_load`=1 and the FIFO not full, write `load_data` at the write pointer. Pointers wrap modulo DEPTH.
- Push while full: the byte is dropped and `overflow` is set. `overflow` is cleared only by `reset`.
- Push and pop on the same edge while full: both take effect; the push is not dropped and `overflow` does not change.
- `UART_TE` = (`fifo_level` != DEPTH). It is combinational from registered state.
- FSM states:
  - IDLE: if the FIFO is non-empty and `tx_busy`=0, go to START. Otherwise stay.
  - START: `tx_start`=1 for exactly this cycle; `tx_data` is loaded on entry; pop the head. Next state is WAIT_BUSY.
  - WAIT_BUSY: if `tx_busy`=1, go to WAIT_DONE. If the counter reaches BUSY_TIMEOUT, return to IDLE. The popped byte is not retried.
  - WAIT_DONE: when `tx_busy`=0, go to IDLE.
- `tx_start` and `tx_data` are registered outputs.
- Bytes are sent in strict load order. No byte is duplicated, except for the CR insertion described under Configuration.
- Reset asserted mid-transfer: the FSM returns to IDLE, the FIFO empties and `tx_start` drops immediately. The serializer is not notified.

## Timing
- Load at edge k into an empty FIFO with `tx_busy`=0:
  - `fifo_level`=1 after edge k.
  - START entered at edge k+1; `tx_start`=1 and `tx_data` valid during cycle k+1.
  - `fifo_level`=0 after edge k+2.
- Minimum spacing between `tx_start` pulses is 4 cycles (START, WAIT_BUSY, WAIT_DONE, IDLE).
- The timeout counter is cleared on entering WAIT_BUSY and increments once per cycle spent in WAIT_BUSY.
- `UART_TE` tracks `fifo_level` in the same cycle; there is no extra latency.

## Configuration
- `UART_TX_CRLF_EN` defined:
  - In IDLE, if the head byte is 8'h0A and `cr_pending`=0, the START cycle sends 8'h0D without popping and sets `cr_pending`.
  - The next START sends 8'h0A, pops it, and clears `cr_pending`.
  - The inserted CR does not occupy a FIFO entry and does not affect `fifo_level`.
- `UART_TX_CRLF_EN` undefined: all bytes pass unchanged; the `cr_pending` logic is absent.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, START, WAIT_BUSY, WAIT_DONE);
  - the constants `ASCII_LF`=8'h0A and `ASCII_CR`=8'h0D.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push/pop/full/empty/level outputs and same-edge push+pop support when full. The scheduler FSM and timeout counter stay in the top module.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> all outputs take their reset values before the next edge; `UART_TE`=1.
- Single byte: load 8'h41, serializer model raises `tx_busy` 1 cycle after `tx_start` and holds it 10 cycles -> exactly one `tx_start`, one cycle after the load, with `tx_data`=8'h41; `fifo_level` returns to 0.
- Fill/overflow: hold `tx_busy`=1, load 8'h01..8'h05 with DEPTH=4 -> `UART_TE`=0 after the 4th load; 8'h05 dropped; `overflow`=1; when drained, bytes arrive in order 01, 02, 03, 04.
- Push+pop while full: with the FIFO full and START occurring, load 8'hAA on the pop edge -> accepted; `overflow` stays 0; `fifo_level` stays 4.
- Timeout: `tx_busy` held 0 after `tx_start` -> FSM returns to IDLE after 15 cycles in WAIT_BUSY; the next byte starts on the following cycle.
- CRLF (with `UART_TX_CRLF_EN`): load 8'h0A -> `tx_data` sequence 8'h0D then 8'h0A; `fifo_level` goes 1, 1, 0. Without the macro, only 8'h0A is sent.
